mem_lane_unit: RTL and testbench

Parametrised load/store lane unit in the M stage, sitting between the pipeline and the data-memory bus. It takes a sized load/store request, generates byte enables and lane-shifted store data, extracts and sign/zero-extends load data, and flags address exceptions. It replaces purely combinational byte-enable decoding with a sequential bus handshake. Optionally, it splits misaligned accesses into two bus beats, holding off the pipeline until the access completes.

---
 rtl/mem_lane_unit_pkg.sv | 26 ++
 rtl/mem_lane_unit_if.sv | 46 ++++
 rtl/mem_lane_unit_align.sv | 33 +++
 rtl/mem_lane_unit.sv | 151 +++++++++++++++
 tb/tb_mem_lane_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lane_unit_pkg.sv
// rtl/mem_lane_unit_pkg.sv - shared constants for the load/store lane unit
// Size codes, address-exception codes, FSM state encoding and a size helper.
package mem_lane_unit_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lane_state_e;

    // Access width in bytes for a size code.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_lane_unit_if.sv
// rtl/mem_lane_unit_if.sv - request, bus and response bundle of the lane unit
// Ports: req_* (pipeline request), bus_* (data-memory beat), rsp_* (completion).
// slave modport is the lane unit; master modport is the pipeline/memory side.
interface mem_lane_unit_if #(
    parameter int DATA_W = 32
);
    localparam int NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              bus_valid;
    logic              bus_ready;
    logic              bus_we;
    logic [31:0]       bus_addr;
    logic [NB-1:0]     bus_byteen;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_exc;
    logic [4:0]        rsp_exc_code;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output bus_valid, bus_we, bus_addr, bus_byteen, bus_wdata,
        input  bus_ready, bus_rdata,
        output rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  bus_valid, bus_we, bus_addr, bus_byteen, bus_wdata,
        output bus_ready, bus_rdata,
        input  rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code
    );

endinterface

// File: rtl/mem_lane_unit_align.sv
// rtl/mem_lane_unit_align.sv - byte-enable mask and store-data lane shifter
// Ports: i_off (byte offset in beat), i_size (size code), i_wdata (right-justified
// store data); o_mask (2*NB lane enables), o_wdata (2*DATA_W shifted data).
// The low half feeds beat 0, the high half feeds beat 1 of a split access.
module mem_lane_align
    import mem_lane_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [OFF_W-1:0]    i_off,
    input  logic [1:0]          i_size,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [2*NB-1:0]     o_mask,
    output logic [2*DATA_W-1:0] o_wdata
);

    logic [2*NB-1:0] w_base;

    always_comb begin
        w_base = '0;
        case (i_size)
            SZ_B:    w_base = (2*NB)'(8'h01);
            SZ_H:    w_base = (2*NB)'(8'h03);
            SZ_W:    w_base = (2*NB)'(8'h0F);
            default: w_base = (2*NB)'(8'hFF);
        endcase
        o_mask  = w_base << i_off;
        o_wdata = {{DATA_W{1'b0}}, i_wdata} << {i_off, 3'b000};
    end

endmodule

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - M-stage load/store lane unit with bus handshake
// Ports: clk, reset (async, active-high), lane (mem_lane_unit_if.slave):
// accepts one sized request in IDLE, issues one or two bus beats, then pulses
// rsp_valid with extended load data or an address exception.
module mem_lane_unit
    import mem_lane_unit_pkg::*;
#(
    parameter int DATA_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    mem_lane_unit_if.slave lane
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lane_state_e         r_state, w_state_next;
    logic                r_we, r_signed;
    logic [1:0]          r_size;
    logic [OFF_W-1:0]    r_off;
    logic [31:0]         r_base;
    logic [DATA_W-1:0]   r_wdata;
    logic [2*DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_exc;
    logic [4:0]          r_rsp_code;

    logic                w_accept, w_exc, w_misalign, w_size_bad, w_split;
    logic [3:0]          w_bytes;
    logic [2*NB-1:0]     w_mask;
    logic [2*DATA_W-1:0] w_wide_wdata, w_rdata_next;
    logic [DATA_W-1:0]   w_low, w_keep, w_ext;
    logic                w_sign, w_beat_done;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_off   (r_off),
        .i_size  (r_size),
        .i_wdata (r_wdata),
        .o_mask  (w_mask),
        .o_wdata (w_wide_wdata)
    );

    assign lane.req_ready = (r_state == ST_IDLE) & ~reset;
    assign w_accept       = lane.req_valid & lane.req_ready;

    // Exception checks are made on the live request so no beat is ever issued.
    assign w_bytes    = size_bytes(lane.req_size);
    assign w_size_bad = (lane.req_size == SZ_D) && (DATA_W < 64);
    assign w_misalign = (lane.req_addr[3:0] & (w_bytes - 4'd1)) != 4'd0;
    assign w_exc      = w_size_bad | (w_misalign & ~SPLIT_MISALIGNED);

    // Any enabled lane in the upper half means the access crosses the beat.
    assign w_split     = |w_mask[2*NB-1:NB];
    assign w_beat_done = ((r_state == ST_BEAT0) || (r_state == ST_BEAT1)) && lane.bus_ready;

    // Merge the beat being accepted now so the response can be registered
    // on the same edge that enters RESP.
    always_comb begin
        w_rdata_next = r_rdata;
        if (r_state == ST_BEAT0) w_rdata_next[DATA_W-1:0]        = lane.bus_rdata;
        if (r_state == ST_BEAT1) w_rdata_next[2*DATA_W-1:DATA_W] = lane.bus_rdata;
        w_low = DATA_W'(w_rdata_next >> {r_off, 3'b000});
        case (r_size)
            SZ_B:    begin w_keep = DATA_W'(64'hFF);        w_sign = w_low[7];        end
            SZ_H:    begin w_keep = DATA_W'(64'hFFFF);      w_sign = w_low[15];       end
            SZ_W:    begin w_keep = DATA_W'(64'hFFFF_FFFF); w_sign = w_low[31];       end
            default: begin w_keep = '1;                     w_sign = w_low[DATA_W-1]; end
        endcase
        w_ext = (w_low & w_keep) | ((r_signed & w_sign) ? ~w_keep : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        lane.bus_valid  = 1'b0;
        lane.bus_we     = 1'b0;
        lane.bus_addr   = '0;
        lane.bus_byteen = '0;
        lane.bus_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = w_exc ? ST_RESP : ST_BEAT0;
            end
            ST_BEAT0: begin
                lane.bus_valid  = 1'b1;
                lane.bus_we     = r_we;
                lane.bus_addr   = r_base;
                lane.bus_byteen = w_mask[NB-1:0];
                lane.bus_wdata  = w_wide_wdata[DATA_W-1:0];
                if (lane.bus_ready) w_state_next = w_split ? ST_BEAT1 : ST_RESP;
            end
            ST_BEAT1: begin
                lane.bus_valid  = 1'b1;
                lane.bus_we     = r_we;
                lane.bus_addr   = r_base + 32'(NB);
                lane.bus_byteen = w_mask[2*NB-1:NB];
                lane.bus_wdata  = w_wide_wdata[2*DATA_W-1:DATA_W];
                if (lane.bus_ready) w_state_next = ST_RESP;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= SZ_B;
            r_off       <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_exc   <= 1'b0;
            r_rsp_code  <= EXC_NONE;
        end else begin
            if (w_accept) begin
                r_we     <= lane.req_we;
                r_signed <= lane.req_signed;
                r_size   <= lane.req_size;
                r_off    <= lane.req_addr[OFF_W-1:0];
                r_base   <= lane.req_addr & ~32'(NB - 1);
                r_wdata  <= lane.req_wdata;
                r_rdata  <= '0;
            end
            if (w_accept && w_exc) begin
                r_rsp_rdata <= '0;
                r_rsp_exc   <= 1'b1;
                r_rsp_code  <= lane.req_we ? EXC_ADES : EXC_ADEL;
            end
            if (w_beat_done) r_rdata <= w_rdata_next;
            if (w_beat_done && (w_state_next == ST_RESP)) begin
                r_rsp_rdata <= r_we ? '0 : w_ext;
                r_rsp_exc   <= 1'b0;
                r_rsp_code  <= EXC_NONE;
            end
        end
    end

    assign lane.rsp_valid    = (r_state == ST_RESP);
    assign lane.rsp_rdata    = r_rsp_rdata;
    assign lane.rsp_exc      = r_rsp_exc;
    assign lane.rsp_exc_code = r_rsp_code;

endmodule

// File: tb/tb_mem_lane_unit.sv
// tb/tb_mem_lane_unit.sv - directed self-checking bench for mem_lane_unit
module tb_mem_lane_unit;
    import mem_lane_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        req_valid, req_we, req_signed, bus_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, bus_rdata;

    mem_lane_unit_if #(.DATA_W(32)) if0 ();
    mem_lane_unit_if #(.DATA_W(32)) if1 ();

    mem_lane_unit #(.DATA_W(32), .SPLIT_MISALIGNED(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .lane  (if0)
    );

    mem_lane_unit #(.DATA_W(32), .SPLIT_MISALIGNED(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .lane  (if1)
    );

    assign if0.req_valid  = req_valid & ~sel;
    assign if1.req_valid  = req_valid & sel;
    assign if0.req_we     = req_we;     assign if1.req_we     = req_we;
    assign if0.req_size   = req_size;   assign if1.req_size   = req_size;
    assign if0.req_signed = req_signed; assign if1.req_signed = req_signed;
    assign if0.req_addr   = req_addr;   assign if1.req_addr   = req_addr;
    assign if0.req_wdata  = req_wdata;  assign if1.req_wdata  = req_wdata;
    assign if0.bus_ready  = bus_ready;  assign if1.bus_ready  = bus_ready;
    assign if0.bus_rdata  = bus_rdata;  assign if1.bus_rdata  = bus_rdata;

    logic        o_req_ready, o_bus_valid, o_bus_we, o_rsp_valid, o_rsp_exc;
    logic [31:0] o_bus_addr, o_bus_wdata, o_rsp_rdata;
    logic [3:0]  o_bus_byteen;
    logic [4:0]  o_rsp_code;

    assign o_req_ready  = sel ? if1.req_ready    : if0.req_ready;
    assign o_bus_valid  = sel ? if1.bus_valid    : if0.bus_valid;
    assign o_bus_we     = sel ? if1.bus_we       : if0.bus_we;
    assign o_bus_addr   = sel ? if1.bus_addr     : if0.bus_addr;
    assign o_bus_byteen = sel ? if1.bus_byteen   : if0.bus_byteen;
    assign o_bus_wdata  = sel ? if1.bus_wdata    : if0.bus_wdata;
    assign o_rsp_valid  = sel ? if1.rsp_valid    : if0.rsp_valid;
    assign o_rsp_rdata  = sel ? if1.rsp_rdata    : if0.rsp_rdata;
    assign o_rsp_exc    = sel ? if1.rsp_exc      : if0.rsp_exc;
    assign o_rsp_code   = sel ? if1.rsp_exc_code : if0.rsp_exc_code;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] b_addr [2];
    logic [31:0] b_wd   [2];
    logic [3:0]  b_be   [2];
    logic        stable_ok;
    logic        got_exc;
    logic [4:0]  got_code;
    logic [31:0] got_rdata;
    int          lat, nb;

    // Presents one request, then plays the memory: beat 0 may be stalled
    // for 'stall0' cycles. Latency counts cycles from the accept cycle to
    // the cycle showing rsp_valid.
    task automatic access(input logic s, input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd0, input logic [31:0] rd1, input int stall0);
        int   stall;
        logic seen, done;
        @(negedge clk);
        sel = s; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; req_valid = 1'b1; bus_ready = 1'b0;
        chk("req_ready_idle", o_req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nb = 0; stall = stall0; seen = 1'b0; done = 1'b0; stable_ok = 1'b1;
        for (int c = 0; c < 32 && !done; c++) begin
            if (o_rsp_valid) begin
                done      = 1'b1;
                got_exc   = o_rsp_exc;
                got_code  = o_rsp_code;
                got_rdata = o_rsp_rdata;
            end else begin
                bus_ready = 1'b0;
                if (o_bus_valid && nb < 2) begin
                    if (seen && (o_bus_addr !== b_addr[nb] || o_bus_byteen !== b_be[nb] ||
                                 o_bus_wdata !== b_wd[nb] || o_bus_we !== we))
                        stable_ok = 1'b0;
                    b_addr[nb] = o_bus_addr; b_be[nb] = o_bus_byteen; b_wd[nb] = o_bus_wdata;
                    seen = 1'b1;
                    if (nb == 0 && stall > 0) begin
                        stall--;
                    end else begin
                        bus_ready = 1'b1;
                        bus_rdata = (nb == 0) ? rd0 : rd1;
                        nb++;
                        seen = 1'b0;
                    end
                end
                @(negedge clk);
                lat++;
            end
        end
        bus_ready = 1'b0;
        chk("rsp_seen", done, 1'b1);
    endtask

    logic saw_rsp;

    initial begin
        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_bus_valid", o_bus_valid, 0);
        chk("rst_bus_byteen", o_bus_byteen, 0);
        chk("rst_bus_wdata", o_bus_wdata, 0);
        chk("rst_bus_addr", o_bus_addr, 0);
        chk("rst_bus_we", o_bus_we, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_rdata", o_rsp_rdata, 0);
        chk("rst_rsp_exc", o_rsp_exc, 0);
        chk("rst_rsp_code", o_rsp_code, 0);
        sel = 1'b1;
        chk("rst_req_ready1", o_req_ready, 0);
        reset = 1'b0;

        // aligned store word
        access(0, 1, SZ_W, 0, 32'h100, 32'h12345678, 0, 0, 0);
        chk("sw_lat", lat, 2);       chk("sw_beats", nb, 1);
        chk("sw_addr", b_addr[0], 32'h100);
        chk("sw_be", b_be[0], 4'hF); chk("sw_wd", b_wd[0], 32'h12345678);
        chk("sw_exc", got_exc, 0);   chk("sw_rdata", got_rdata, 0);

        // byte loads, signed and unsigned
        access(0, 0, SZ_B, 1, 32'h203, 0, 32'h80AABBCC, 0, 0);
        chk("lb_s_be", b_be[0], 4'h8); chk("lb_s_addr", b_addr[0], 32'h200);
        chk("lb_s_rdata", got_rdata, 32'hFFFFFF80); chk("lb_s_lat", lat, 2);
        access(0, 0, SZ_B, 0, 32'h203, 0, 32'h80AABBCC, 0, 0);
        chk("lb_u_rdata", got_rdata, 32'h00000080);

        // misaligned exceptions without splitting
        access(0, 0, SZ_W, 0, 32'h102, 0, 0, 0, 0);
        chk("lw_mis_beats", nb, 0); chk("lw_mis_lat", lat, 1);
        chk("lw_mis_exc", got_exc, 1); chk("lw_mis_code", got_code, 4);
        access(0, 1, SZ_H, 0, 32'h101, 32'h1234, 0, 0, 0);
        chk("sh_mis_beats", nb, 0); chk("sh_mis_code", got_code, 5);

        // dword illegal at 32 bits, both split settings
        access(0, 0, SZ_D, 0, 32'h108, 0, 0, 0, 0);
        chk("ld_exc", got_exc, 1); chk("ld_code", got_code, 4); chk("ld_beats", nb, 0);
        access(1, 1, SZ_D, 0, 32'h108, 0, 0, 0, 0);
        chk("sd_split_exc", got_exc, 1); chk("sd_split_code", got_code, 5);
        chk("sd_split_lat", lat, 1);

        // aligned load on the split unit
        access(1, 0, SZ_W, 0, 32'h40, 0, 32'h11223344, 0, 0);
        chk("lw_sp_lat", lat, 2); chk("lw_sp_rdata", got_rdata, 32'h11223344);
        chk("lw_sp_exc", got_exc, 0);

        // split store word
        access(1, 1, SZ_W, 0, 32'h103, 32'hAABBCCDD, 0, 0, 0);
        chk("sw_sp_lat", lat, 3); chk("sw_sp_beats", nb, 2);
        chk("sw_sp_a0", b_addr[0], 32'h100); chk("sw_sp_be0", b_be[0], 4'h8);
        chk("sw_sp_wd0", b_wd[0], 32'hDD000000);
        chk("sw_sp_a1", b_addr[1], 32'h104); chk("sw_sp_be1", b_be[1], 4'h7);
        chk("sw_sp_wd1", b_wd[1], 32'h00AABBCC);

        // split signed half at the top of memory, stalled beat 0
        access(1, 0, SZ_H, 1, 32'hFFFFFFFF, 0, 32'hFE000000, 32'h000000FF, 3);
        chk("lh_wrap_lat", lat, 6); chk("lh_wrap_stable", stable_ok, 1);
        chk("lh_wrap_a0", b_addr[0], 32'hFFFFFFFC); chk("lh_wrap_be0", b_be[0], 4'h8);
        chk("lh_wrap_a1", b_addr[1], 32'h00000000); chk("lh_wrap_be1", b_be[1], 4'h1);
        chk("lh_wrap_rdata", got_rdata, 32'hFFFFFFFE);
        @(negedge clk);
        chk("rsp_one_cycle", o_rsp_valid, 0);
        chk("rsp_rdata_hold", o_rsp_rdata, 32'hFFFFFFFE);

        // reset during the second beat
        @(negedge clk);
        sel = 1'b1; req_we = 1'b1; req_size = SZ_W; req_signed = 1'b0;
        req_addr = 32'h103; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_beat1", o_bus_valid, 1);
        chk("rst_mid_addr", o_bus_addr, 32'h104);
        bus_ready = 1'b0;
        #2 reset = 1'b1;
        #1 chk("rst_async_bv", o_bus_valid, 0);
        saw_rsp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (o_rsp_valid) saw_rsp = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_valid) saw_rsp = 1'b1;
        end
        chk("rst_no_rsp", saw_rsp, 0);
        access(1, 1, SZ_W, 0, 32'h0, 32'hCAFEF00D, 0, 0, 0);
        chk("post_rst_lat", lat, 2); chk("post_rst_addr", b_addr[0], 32'h0);
        chk("post_rst_be", b_be[0], 4'hF); chk("post_rst_wd", b_wd[0], 32'hCAFEF00D);
        chk("post_rst_exc", got_exc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
